// File: rtl/down_timer7.sv
// Loadable 4-bit countdown timer with prescaler, expiry pulse and 7-segment output.
// Optional periodic mode: define DOWN_TIMER7_AUTO_RELOAD_EN to reload on expiry instead of stopping.
module down_timer7 #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] q,
  output logic [6:0] dout,
  output logic       zero,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TICK_AT = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    q_q, q_d;
  logic [3:0]    reload_q, reload_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          running_q, running_d;
  logic          tick_c;

  assign tick_c = (presc_q == TICK_AT);

  // Next-state: load > stop > start > tick; a stop in IDLE also blocks start.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      presc_d  = '0;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!stop && start && (q_q != 4'd0)) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
            presc_d = '0;
          end else if (tick_c) begin
            presc_d = '0;
            if (q_q == 4'd1) begin
              done_d = 1'b1;
`ifdef DOWN_TIMER7_AUTO_RELOAD_EN
              q_d    = reload_q;
`else
              q_d     = 4'd0;
              state_d = EXPIRED;
`endif
            end else begin
              q_d = q_q - 4'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      q_q       <= 4'd0;
      reload_q  <= 4'd0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  // BCD to 7-segment, active-high {g,f,e,d,c,b,a}; non-decimal codes blank the display.
  always_comb begin
    dout = 7'h00;
    unique case (q_q)
      4'd0: dout = 7'h3F;
      4'd1: dout = 7'h06;
      4'd2: dout = 7'h5B;
      4'd3: dout = 7'h4F;
      4'd4: dout = 7'h66;
      4'd5: dout = 7'h6D;
      4'd6: dout = 7'h7D;
      4'd7: dout = 7'h07;
      4'd8: dout = 7'h7F;
      4'd9: dout = 7'h6F;
      default: dout = 7'h00;
    endcase
  end

  assign q       = q_q;
  assign zero    = (q_q == 4'd0);
  assign running = running_q;
  assign done    = done_q;

endmodule
